// File: rtl/uart_rx_os.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_os                                                    |
// | Oversampling UART receiver: 2-of-3 majority sampling, false-start reject,|
// | runtime word/parity/stop config, break detect, valid/ready holding reg.  |
// | Optional : UART_RX_OS_TIMEOUT_EN (idle timeout on a held word)           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_rx_os #(
  parameter int DATA_W_MAX = 9,
  parameter int OS_RATE    = 16,
  parameter int DIV_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic [DIV_W-1:0]      i_baud_div,
  input  logic [3:0]            i_data_bits,
  input  logic [2:0]            i_parity_mode,
  input  logic                  i_two_stop,
  input  logic                  i_msb_first,
  input  logic                  i_rx,
  input  logic                  i_rx_ready,
`ifdef UART_RX_OS_TIMEOUT_EN
  input  logic [7:0]            i_timeout_bits,
  output logic                  o_rx_timeout,
`endif
  output logic                  o_rx_valid,
  output logic [DATA_W_MAX-1:0] o_rx_data,
  output logic                  o_parity_error,
  output logic                  o_frame_error,
  output logic                  o_break,
  output logic                  o_overrun,
  output logic                  o_rx_busy,
  output logic                  o_rts
);

  localparam int                   c_os_w    = $clog2(OS_RATE);
  localparam logic [c_os_w-1:0]    c_os_last = c_os_w'(OS_RATE - 1);
  localparam logic [c_os_w-1:0]    c_os_s0   = c_os_w'(OS_RATE / 2 - 1);
  localparam logic [c_os_w-1:0]    c_os_s1   = c_os_w'(OS_RATE / 2);
  localparam logic [c_os_w-1:0]    c_os_s2   = c_os_w'(OS_RATE / 2 + 1);
  localparam logic [3:0]           c_dmax    = 4'(DATA_W_MAX);
  localparam logic [DATA_W_MAX-1:0] c_one    = DATA_W_MAX'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START      = 3'd1,
    S_DATA       = 3'd2,
    S_PARITY     = 3'd3,
    S_STOP       = 3'd4,
    S_BREAK_WAIT = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic                    r_rx_meta;
  logic                    r_rx_s;
  logic                    r_rx_prev;
  logic [DIV_W-1:0]        r_div_cnt;
  logic [c_os_w-1:0]       r_os;
  logic [1:0]              r_smp;
  logic [3:0]              r_nbits;
  logic [2:0]              r_par_mode;
  logic                    r_two_stop;
  logic [3:0]              r_bit_cnt;
  logic [DATA_W_MAX-1:0]   r_data;
  logic                    r_par_err;
  logic                    r_frm_err;
  logic                    r_all_zero;

  logic                    r_valid;
  logic [DATA_W_MAX-1:0]   r_hold_data;
  logic                    r_hold_perr;
  logic                    r_hold_ferr;
  logic                    r_break;
  logic                    r_overrun;

  logic                    w_start;
  logic                    w_tick_run;
  logic                    w_tick;
  logic                    w_res;
  logic                    w_bit_end;
  logic                    w_maj;
  logic                    w_done;
  logic                    w_brk_det;
  logic                    w_hs;
  logic [3:0]              w_nbits_clamp;
  logic [2:0]              w_par_norm;
  logic [3:0]              w_idx;
  logic [DATA_W_MAX-1:0]   w_bit_mask;
  logic                    w_par_exp;

  // Input synchroniser plus one extra flop for falling-edge detection
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_start = (r_state == S_IDLE) && r_rx_prev && !r_rx_s;

`ifdef UART_RX_OS_TIMEOUT_EN
  assign w_tick_run = 1'b1;
`else
  assign w_tick_run = (r_state != S_IDLE);
`endif

  assign w_tick    = w_tick_run && (r_div_cnt == i_baud_div);
  assign w_res     = w_tick && (r_os == c_os_s2);
  assign w_bit_end = w_tick && (r_os == c_os_last);
  assign w_maj     = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_rx_s) | (r_smp[1] & r_rx_s);
  assign w_hs      = r_valid && i_rx_ready;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_div_cnt <= '0;
    end else if (w_start || !w_tick_run || (r_div_cnt == i_baud_div)) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Oversample counter; in BREAK_WAIT it measures the continuous-high run
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_os <= '0;
    end else if (w_start || w_brk_det) begin
      r_os <= '0;
    end else if ((r_state == S_BREAK_WAIT) && !r_rx_s) begin
      r_os <= '0;
    end else if (w_tick) begin
      r_os <= (r_os == c_os_last) ? '0 : r_os + c_os_w'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_smp <= 2'b11;
    end else if (w_tick && (r_os == c_os_s0)) begin
      r_smp[0] <= r_rx_s;
    end else if (w_tick && (r_os == c_os_s1)) begin
      r_smp[1] <= r_rx_s;
    end
  end

  always_comb begin
    w_nbits_clamp = i_data_bits;
    if (i_data_bits < 4'd5) begin
      w_nbits_clamp = 4'd5;
    end else if (i_data_bits > c_dmax) begin
      w_nbits_clamp = c_dmax;
    end
    w_par_norm = (i_parity_mode > 3'd4) ? 3'd0 : i_parity_mode;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Completion fires at the mid-sample of the last stop bit so the next start edge is not missed
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_brk_det   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_res && w_maj) begin
          w_state_nxt = S_IDLE;
        end else if (w_bit_end) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end && (r_bit_cnt == (r_nbits - 4'd1))) begin
          w_state_nxt = (r_par_mode != 3'd0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_res && (r_bit_cnt == (r_two_stop ? 4'd1 : 4'd0))) begin
          w_done = 1'b1;
          if (r_all_zero && !w_maj) begin
            w_brk_det   = 1'b1;
            w_state_nxt = S_BREAK_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_BREAK_WAIT: begin
        if (w_tick && r_rx_s && (r_os == c_os_last)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_idx      = i_msb_first ? (r_nbits - 4'd1 - r_bit_cnt) : r_bit_cnt;
  assign w_bit_mask = c_one << w_idx;

  always_comb begin
    case (r_par_mode)
      3'd1:    w_par_exp = ^r_data;
      3'd2:    w_par_exp = ~(^r_data);
      3'd3:    w_par_exp = 1'b1;
      default: w_par_exp = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_nbits    <= 4'd5;
      r_par_mode <= 3'd0;
      r_two_stop <= 1'b0;
      r_bit_cnt  <= 4'd0;
      r_data     <= '0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_all_zero <= 1'b1;
    end else if (w_start) begin
      r_nbits    <= w_nbits_clamp;
      r_par_mode <= w_par_norm;
      r_two_stop <= i_two_stop;
      r_bit_cnt  <= 4'd0;
      r_data     <= '0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_all_zero <= 1'b1;
    end else begin
      if (w_res && ((r_state == S_DATA) || (r_state == S_PARITY) || (r_state == S_STOP))) begin
        r_all_zero <= r_all_zero & ~w_maj;
      end
      if ((r_state == S_DATA) && w_res && w_maj) begin
        r_data <= r_data | w_bit_mask;
      end
      if ((r_state == S_DATA) && w_bit_end) begin
        r_bit_cnt <= (r_bit_cnt == (r_nbits - 4'd1)) ? 4'd0 : r_bit_cnt + 4'd1;
      end
      if ((r_state == S_STOP) && w_bit_end) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if ((r_state == S_PARITY) && w_res) begin
        r_par_err <= (w_maj != w_par_exp);
      end
      if ((r_state == S_STOP) && w_res && !w_maj) begin
        r_frm_err <= 1'b1;
      end
    end
  end

  // Holding register: a completed word loads only if the slot is free or being drained now
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_valid     <= 1'b0;
      r_hold_data <= '0;
      r_hold_perr <= 1'b0;
      r_hold_ferr <= 1'b0;
      r_break     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_break   <= w_done && w_brk_det;
      r_overrun <= 1'b0;
      if (w_done && !w_brk_det) begin
        if (!r_valid || w_hs) begin
          r_valid     <= 1'b1;
          r_hold_data <= r_data;
          r_hold_perr <= r_par_err;
          r_hold_ferr <= r_frm_err | ~w_maj;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_hs) begin
        r_valid     <= 1'b0;
        r_hold_data <= '0;
        r_hold_perr <= 1'b0;
        r_hold_ferr <= 1'b0;
      end
    end
  end

`ifdef UART_RX_OS_TIMEOUT_EN
  logic [7:0] r_idle_cnt;
  logic       r_to_fired;
  logic       r_to_pulse;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_idle_cnt <= 8'd0;
      r_to_fired <= 1'b0;
      r_to_pulse <= 1'b0;
    end else begin
      r_to_pulse <= 1'b0;
      if (w_start || w_hs) begin
        r_idle_cnt <= 8'd0;
        r_to_fired <= 1'b0;
      end else if ((r_state == S_IDLE) && r_valid) begin
        if (w_bit_end && (r_idle_cnt != 8'hFF)) begin
          r_idle_cnt <= r_idle_cnt + 8'd1;
        end
        if (!r_to_fired && (i_timeout_bits != 8'd0) && (r_idle_cnt == i_timeout_bits)) begin
          r_to_pulse <= 1'b1;
          r_to_fired <= 1'b1;
        end
      end
    end
  end

  assign o_rx_timeout = r_to_pulse;
`endif

  assign o_rx_valid     = r_valid;
  assign o_rx_data      = r_hold_data;
  assign o_parity_error = r_hold_perr;
  assign o_frame_error  = r_hold_ferr;
  assign o_break        = r_break;
  assign o_overrun      = r_overrun;
  assign o_rx_busy      = (r_state != S_IDLE);
  assign o_rts          = !r_valid || i_rx_ready;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx_os                                                 |
// | Directed bench for uart_rx_os, OS_RATE=16, baud_div=3 (64 clks per bit). |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_uart_rx_os;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic [3:0] data_bits = 4'd8;
  logic [2:0] parity_mode = 3'd0;
  logic       two_stop = 1'b0;
  logic       msb_first = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic       rx_valid;
  logic [8:0] rx_data;
  logic       parity_error;
  logic       frame_error;
  logic       brk;
  logic       overrun;
  logic       rx_busy;
  logic       rts;

  int checks = 0;
  int errors = 0;
  int got_cnt = 0;
  int vcyc = 0;
  int brk_cnt = 0;
  int ovr_cnt = 0;
  logic [8:0] got_data = '0;
  logic       got_pe = 1'b0;
  logic       got_fe = 1'b0;

  always #5 clk = ~clk;

  uart_rx_os #(.DATA_W_MAX(9), .OS_RATE(16), .DIV_W(16)) dut (
    .i_clk(clk), .i_nrst(rst_n), .i_baud_div(baud_div), .i_data_bits(data_bits),
    .i_parity_mode(parity_mode), .i_two_stop(two_stop), .i_msb_first(msb_first),
    .i_rx(rx), .i_rx_ready(rx_ready), .o_rx_valid(rx_valid), .o_rx_data(rx_data),
    .o_parity_error(parity_error), .o_frame_error(frame_error), .o_break(brk),
    .o_overrun(overrun), .o_rx_busy(rx_busy), .o_rts(rts)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) vcyc++;
      if (rx_valid && rx_ready) begin
        got_cnt++;
        got_data = rx_data;
        got_pe   = parity_error;
        got_fe   = frame_error;
      end
      if (brk) brk_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // glitch_bit >= 0 inverts that data bit for one oversample tick around its centre
  task automatic send_frame(input logic [8:0] w, input int nb, input int par_en,
                            input logic par_b, input int nstop, input logic stop_v,
                            input int glitch_bit);
    logic b;
    drive(1'b0, BIT);
    for (int i = 0; i < nb; i++) begin
      b = msb_first ? w[nb-1-i] : w[i];
      if (i == glitch_bit) begin
        drive(b, 34);
        drive(~b, 4);
        drive(b, BIT - 38);
      end else begin
        drive(b, BIT);
      end
    end
    if (par_en != 0) drive(par_b, BIT);
    for (int s = 0; s < nstop; s++) drive(stop_v, BIT);
    drive(1'b1, 20);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int g0;
    int o0;
    int b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rts", {31'd0, rts}, 32'd1);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    chk("rst_data", {23'd0, rx_data}, 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 10);

    // 8N1 0xA5 LSB first
    v0 = vcyc; g0 = got_cnt;
    send_frame(9'h0A5, 8, 0, 1'b0, 1, 1'b1, -1);
    chk("t1_words", got_cnt - g0, 32'd1);
    chk("t1_vcyc", vcyc - v0, 32'd1);
    chk("t1_data", {23'd0, got_data}, 32'h0A5);
    chk("t1_pe", {31'd0, got_pe}, 32'd0);
    chk("t1_fe", {31'd0, got_fe}, 32'd0);

    // 7O2 MSB first, correct then flipped parity
    data_bits = 4'd7; parity_mode = 3'd2; two_stop = 1'b1; msb_first = 1'b1;
    send_frame(9'h05A, 7, 1, 1'b1, 2, 1'b1, -1);
    chk("t2a_data", {23'd0, got_data}, 32'h05A);
    chk("t2a_pe", {31'd0, got_pe}, 32'd0);
    send_frame(9'h05A, 7, 1, 1'b0, 2, 1'b1, -1);
    chk("t2b_data", {23'd0, got_data}, 32'h05A);
    chk("t2b_pe", {31'd0, got_pe}, 32'd1);
    data_bits = 4'd8; parity_mode = 3'd0; two_stop = 1'b0; msb_first = 1'b0;

    // False start: low for 5 ticks
    g0 = got_cnt;
    drive(1'b0, 10);
    chk("t3_busy_hi", {31'd0, rx_busy}, 32'd1);
    drive(1'b0, 10);
    drive(1'b1, 44);
    chk("t3_busy_lo", {31'd0, rx_busy}, 32'd0);
    drive(1'b1, 40);
    chk("t3_words", got_cnt - g0, 32'd0);

    // Single-tick glitch in data bit 3 of 0x00
    send_frame(9'h000, 8, 0, 1'b0, 1, 1'b1, 3);
    chk("t4_data", {23'd0, got_data}, 32'h000);
    chk("t4_fe", {31'd0, got_fe}, 32'd0);

    // data_bits above max clamps to 9
    data_bits = 4'd15;
    send_frame(9'h1A5, 9, 0, 1'b0, 1, 1'b1, -1);
    chk("t5_data9", {23'd0, got_data}, 32'h1A5);
    // data_bits below min clamps to 5, mark parity
    data_bits = 4'd2; parity_mode = 3'd3;
    send_frame(9'h015, 5, 1, 1'b1, 1, 1'b1, -1);
    chk("t5_data5", {23'd0, got_data}, 32'h015);
    chk("t5_mark_pe", {31'd0, got_pe}, 32'd0);
    data_bits = 4'd8; parity_mode = 3'd0;

    // Stop bit low -> frame error
    send_frame(9'h081, 8, 0, 1'b0, 1, 1'b0, -1);
    chk("t6_data", {23'd0, got_data}, 32'h081);
    chk("t6_fe", {31'd0, got_fe}, 32'd1);

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(9'h03C, 8, 0, 1'b0, 1, 1'b1, -1);
    chk("t7_valid", {31'd0, rx_valid}, 32'd1);
    chk("t7_rts", {31'd0, rts}, 32'd0);
    chk("t7_ovr0", ovr_cnt - o0, 32'd0);
    send_frame(9'h0C3, 8, 0, 1'b0, 1, 1'b1, -1);
    chk("t7_ovr1", ovr_cnt - o0, 32'd1);
    chk("t7_held", {23'd0, rx_data}, 32'h03C);
    g0 = got_cnt;
    rx_ready = 1'b1;
    drive(1'b1, 2);
    chk("t7_drain", {23'd0, got_data}, 32'h03C);
    chk("t7_drain_n", got_cnt - g0, 32'd1);
    chk("t7_empty", {31'd0, rx_valid}, 32'd0);
    chk("t7_rts1", {31'd0, rts}, 32'd1);

    // Break: 12 bit times low at 8E1
    parity_mode = 3'd1;
    v0 = vcyc; b0 = brk_cnt; o0 = ovr_cnt;
    drive(1'b0, 12 * BIT);
    chk("t8_brk", brk_cnt - b0, 32'd1);
    drive(1'b1, 30);
    chk("t8_wait", {31'd0, rx_busy}, 32'd1);
    drive(1'b1, 70);
    chk("t8_idle", {31'd0, rx_busy}, 32'd0);
    chk("t8_novalid", vcyc - v0, 32'd0);
    chk("t8_noovr", ovr_cnt - o0, 32'd0);
    chk("t8_brk_once", brk_cnt - b0, 32'd1);
    parity_mode = 3'd0;

    // Asynchronous reset mid-frame
    drive(1'b0, 100);
    chk("t9_busy", {31'd0, rx_busy}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("t9_rst_busy", {31'd0, rx_busy}, 32'd0);
    rx = 1'b1;
    drive(1'b1, 3);
    rst_n = 1'b1;
    drive(1'b1, 10);
    chk("t9_valid", {31'd0, rx_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised, oversampling UART receiver for YetAnotherUART. It replaces the single-sample receiver with majority-vote sampling, start-bit validation, and runtime-selectable word length and parity type. It adds break detection and a valid/ready output holding register with overrun reporting. It sits between the synchronised RX pad and the RX FIFO.

Parameters:
DATA_W_MAX, 9, widest supported data word (5..9); also the width of o_rx_data.
OS_RATE, 16, oversample ticks per bit (even, 8..32).
DIV_W, 16, width of the baud divider input.

Ports:
i_clk  in  1  core clock, rising edge.
i_nrst  in  1  asynchronous active-low reset.
i_baud_div  in  DIV_W  clock cycles per oversample tick, minus 1.
i_data_bits  in  4  data bits per frame; values <5 are clamped to 5, values >DATA_W_MAX are clamped to DATA_W_MAX.
i_parity_mode  in  3  0 none, 1 even, 2 odd, 3 mark, 4 space; values 5..7 are treated as none.
i_two_stop  in  1  1 = two stop bits checked, 0 = one.
i_msb_first  in  1  bit order of the received word.
i_rx  in  1  asynchronous serial input.
i_rx_ready  in  1  consumer accepts the held word.
o_rx_valid  out  1  held word available.
o_rx_data  out  DATA_W_MAX  received word, right-aligned, upper bits zero.
o_parity_error  out  1  parity error flag for the held word.
o_frame_error  out  1  stop-bit error flag for the held word.
o_break  out  1  one-cycle pulse when a break is detected.
o_overrun  out  1  one-cycle pulse when a completed word is dropped.
o_rx_busy  out  1  FSM is not in IDLE.
o_rts  out  1  high when the holding register is empty, or is being consumed this cycle.

Behaviour:
- Reset values:
  - all outputs 0, except o_rts, which is 1;
  - FSM in IDLE;
  - synchroniser flops at 1.
- Input path: i_rx passes through a 2-flop synchroniser to give rx_s. All logic uses rx_s, so there are 2 cycles of input latency.
- Tick generator:
  - counter runs 0..i_baud_div and emits tick when count == i_baud_div;
  - it runs freely only while the FSM is outside IDLE, and resets to 0 on start detection;
  - i_baud_div = 0 gives a tick every cycle.
- Oversample counter: 0..OS_RATE-1, advanced on tick.
- Bit sampling: samples are taken at os counts OS_RATE/2-1, OS_RATE/2 and OS_RATE/2+1. The bit value is the 2-of-3 majority, resolved at OS_RATE/2+1.
- Configuration: i_data_bits, i_parity_mode and i_two_stop are latched at start detection. Changes mid-frame have no effect.
- FSM states:
  - IDLE -> START on a falling edge of rx_s.
  - START: if the majority value is 1, the start is false; return to IDLE with no outputs. Otherwise, at the bit end (os = OS_RATE-1 on tick), go to DATA.
  - DATA: shift the majority value into the data register. After the latched data_bits count, go to PARITY if parity is enabled, else STOP.
  - PARITY: sample and compare against the expected value:
    - even: XOR of data == bit;
    - odd: inverse of even;
    - mark: expected 1;
    - space: expected 0.
  - STOP: sample one bit, or two when two-stop is latched. A stop bit error is any stop sample that is 0. Frame completion occurs at the mid-sample of the last stop bit, not the bit end, so back-to-back frames resynchronise on the next start edge. On completion go to IDLE, or to BREAK_WAIT if a break is detected.
  - BREAK_WAIT: hold until rx_s == 1 for one full bit (OS_RATE ticks), then go to IDLE.
- Break: declared when all data, parity and stop samples are 0.
  - o_break pulses once;
  - no word is loaded;
  - o_overrun is not asserted.
- Bit order: with i_msb_first = 0, the first data bit lands in o_rx_data[0]. With i_msb_first = 1, the first data bit lands in o_rx_data[data_bits-1].
- Holding register, at frame completion (non-break):
  - If it is empty, or i_rx_ready && o_rx_valid in the same cycle, load data and error flags and set o_rx_valid on the next cycle.
  - Otherwise, drop the new word, pulse o_overrun, and keep the old word and flags unchanged.
- Handshake: o_rx_valid stays high, with data and flags stable, until the cycle o_rx_valid && i_rx_ready. The register then clears, unless it is reloaded in that same cycle.
- Reset mid-frame: asynchronous return to the reset state, and any partial word is discarded.

Optional Feature:
UART_RX_OS_TIMEOUT_EN
- Enabled: adds input i_timeout_bits [7:0] and output o_rx_timeout.
  - An idle counter counts bit periods (OS_RATE ticks, with the tick generator running in IDLE) while the FSM is in IDLE and o_rx_valid = 1.
  - It is cleared by start detection or by a handshake.
  - When the count reaches i_timeout_bits (non-zero), o_rx_timeout pulses for 1 cycle, once per held word.
  - i_timeout_bits = 0 disables the timeout.
- Disabled: neither the port nor the logic exists, and the tick generator is gated in IDLE.

Test Plan:
- 8N1, OS_RATE = 16, i_baud_div = 3, send 0xA5 LSB first, i_rx_ready = 1 -> o_rx_valid for 1 cycle, o_rx_data = 0x0A5, no error flags.
- 7O2, i_msb_first = 1, send 0x5A with correct parity, then repeat with parity flipped -> first word 0x5A with o_parity_error = 0; second word with o_parity_error = 1.
- Glitch low on i_rx for 5 oversample ticks -> no o_rx_valid and no errors; FSM back in IDLE within one bit period.
- Single-tick inverted glitch at os = OS_RATE/2 inside data bit 3 of 0x00 -> majority rejects it, o_rx_data = 0x000.
- Two frames with i_rx_ready = 0 -> first word held unchanged, o_overrun pulses once at completion of the second frame, o_rts = 0.
- Line held low for 12 bit times at 8E1 -> o_break pulses once, no o_rx_valid; IDLE is re-entered one bit period after the line returns high.
